// File: rtl/addsub_pipe_if.sv
// Operand/result handshake bundle for addsub_pipe.
// ADDSUB_SATURATE_EN adds the per-beat sat flag.
interface addsub_pipe_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             m;
`ifdef ADDSUB_SATURATE_EN
  logic             sat;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             ovf;
  logic             zero;

`ifdef ADDSUB_SATURATE_EN
  modport master (output in_valid, a, b, m, sat, out_ready,
                  input  in_ready, out_valid, s, cout, ovf, zero);
  modport slave  (input  in_valid, a, b, m, sat, out_ready,
                  output in_ready, out_valid, s, cout, ovf, zero);
`else
  modport master (output in_valid, a, b, m, out_ready,
                  input  in_ready, out_valid, s, cout, ovf, zero);
  modport slave  (input  in_valid, a, b, m, out_ready,
                  output in_ready, out_valid, s, cout, ovf, zero);
`endif
endinterface

// File: rtl/addsub_pipe.sv
// Chunked CLA add/sub, STAGES-cycle latency; every stage holds while out_valid && !out_ready.
// ADDSUB_SATURATE_EN adds a per-beat sat input that clamps signed-overflowing results.
module addsub_pipe #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2
) (
  input logic          clk,
  input logic          rst_n,
  addsub_pipe_if.slave io
);
  localparam int C = WIDTH / STAGES;

  typedef struct packed {
    logic [C-1:0] sum;
    logic         c_msb;
    logic         c_out;
  } chunk_t;

  function automatic chunk_t cla(input logic [C-1:0] x, input logic [C-1:0] y, input logic ci);
    chunk_t       r;
    logic [C-1:0] g;
    logic [C-1:0] p;
    logic [C:0]   c;
    logic         gg;
    logic         pp;
    g    = x & y;
    p    = x ^ y;
    c    = '0;
    c[0] = ci;
    for (int i = 0; i < C; i++) begin
      // Group generate/propagate over bits i..0, so every carry depends only on ci.
      gg = g[i];
      pp = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        gg = gg | (pp & g[j]);
        pp = pp & p[j];
      end
      c[i+1] = gg | (pp & ci);
    end
    r.sum   = p ^ c[C-1:0];
    r.c_msb = c[C-1];
    r.c_out = c[C];
    return r;
  endfunction

  logic [STAGES-1:0]            v_q, v_n;
  logic [STAGES-1:0][WIDTH-1:0] a_q, b_q, r_q, a_n, b_n, r_n;
  logic [STAGES-1:0]            c_q, c_n;
  logic                         ovf_q, zero_q, ovf_n, zero_n;
  logic                         advance;
`ifdef ADDSUB_SATURATE_EN
  logic [STAGES-1:0]            sat_q, sat_n;
`endif

  assign advance = !(v_q[STAGES-1] && !io.out_ready);

  always_comb begin
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic [WIDTH-1:0] r_in;
    logic             c_in;
    logic             v_in;
    logic             sat_in;
    chunk_t           ch;
    v_n    = '0;
    a_n    = '0;
    b_n    = '0;
    r_n    = '0;
    c_n    = '0;
    ovf_n  = 1'b0;
    zero_n = 1'b0;
    ch     = '0;
    // b is pre-inverted for subtract, so m only matters as the stage-0 carry-in.
    a_in   = io.a;
    b_in   = io.b ^ {WIDTH{io.m}};
    r_in   = '0;
    c_in   = io.m;
    v_in   = io.in_valid;
`ifdef ADDSUB_SATURATE_EN
    sat_n  = '0;
    sat_in = io.sat;
`else
    sat_in = 1'b0;
`endif
    for (int k = 0; k < STAGES; k++) begin
      ch                = cla(a_in[k*C +: C], b_in[k*C +: C], c_in);
      r_in[k*C +: C]    = ch.sum;
      a_n[k]            = a_in;
      b_n[k]            = b_in;
      r_n[k]            = r_in;
      c_n[k]            = ch.c_out;
      v_n[k]            = v_in;
`ifdef ADDSUB_SATURATE_EN
      sat_n[k]          = sat_in;
`endif
      if (k == STAGES - 1) begin
        ovf_n = ch.c_msb ^ ch.c_out;
        if (sat_in && ovf_n)
          r_n[STAGES-1] = a_in[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        zero_n = (r_n[STAGES-1] == '0);
      end
      a_in   = a_q[k];
      b_in   = b_q[k];
      r_in   = r_q[k];
      c_in   = c_q[k];
      v_in   = v_q[k];
`ifdef ADDSUB_SATURATE_EN
      sat_in = sat_q[k];
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q    <= '0;
      a_q    <= '0;
      b_q    <= '0;
      r_q    <= '0;
      c_q    <= '0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
`ifdef ADDSUB_SATURATE_EN
      sat_q  <= '0;
`endif
    end else if (advance) begin
      v_q <= v_n;
      // Bubbles leave data untouched so the outputs keep their last values.
      for (int k = 0; k < STAGES; k++) begin
        if (v_n[k]) begin
          a_q[k] <= a_n[k];
          b_q[k] <= b_n[k];
          r_q[k] <= r_n[k];
          c_q[k] <= c_n[k];
`ifdef ADDSUB_SATURATE_EN
          sat_q[k] <= sat_n[k];
`endif
        end
      end
      if (v_n[STAGES-1]) begin
        ovf_q  <= ovf_n;
        zero_q <= zero_n;
      end
    end
  end

  assign io.in_ready  = advance;
  assign io.out_valid = v_q[STAGES-1];
  assign io.s         = r_q[STAGES-1];
  assign io.cout      = c_q[STAGES-1];
  assign io.ovf       = ovf_q;
  assign io.zero      = zero_q;
endmodule

// File: doc/addsub_pipe.md
Name: addsub_pipe

Overview:
- Parametrised, pipelined two's-complement adder/subtractor. Next generation of the team's fixed 8-bit combinational CLA adder/subtractor.
- Operand width is split into STAGES equal chunks. One chunk adds per pipeline stage, and the carry between chunks is registered.
- Valid/ready handshake on both sides. Reports carry-out, signed overflow and zero.
- Sits between operand sources (register file or datapath muxes) and ALU result writeback.

Parameters:
- WIDTH, 16, operand/result width in bits. Must be divisible by STAGES, and WIDTH/STAGES must be >= 2.
- STAGES, 2, number of pipeline stages, which is also the latency in cycles. Must be >= 1.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand beat offered.
- in_ready  output  1  block accepts the beat this cycle.
- a  input  WIDTH  minuend / augend.
- b  input  WIDTH  subtrahend / addend.
- m  input  1  mode: 0 = a+b, 1 = a-b.
- out_valid  output  1  result beat valid.
- out_ready  input  1  consumer accepts the result.
- s  output  WIDTH  result.
- cout  output  1  carry out of MSB. For subtract, 1 = no borrow.
- ovf  output  1  signed overflow (carry into MSB XOR carry out of MSB).
- zero  output  1  s == 0.

Behaviour:
- One clock, clk. Reset is asynchronous, active-low, on rst_n.
- Reset: every stage valid bit, out_valid, s, cout, ovf and zero = 0. in_ready = 1 once rst_n is high.
- Reset asserted mid-operation discards all in-flight beats. Nothing is emitted for them.
- Arithmetic: s = a + (b XOR {WIDTH{m}}) + m, mod 2^WIDTH. ovf = c[WIDTH-1] XOR c[WIDTH].
- Chunking: chunk k (bits k*C to k*C+C-1, where C = WIDTH/STAGES) is computed in stage k, using the registered carry from stage k-1. Stage 0 uses m as carry-in.
  - Upper operand chunks and the mode bit are skewed through registers.
  - Lower result chunks are carried forward through registers.
  - Chunk adders are carry-lookahead within the chunk.
- Latency: a beat accepted at edge N appears on out_valid after edge N+STAGES-1, i.e. exactly STAGES cycles from acceptance to result visible, with no stall.
- Throughput: one beat per cycle while out_ready = 1.
- Handshake:
  - Transfer in: in_valid && in_ready at a rising edge.
  - Transfer out: out_valid && out_ready at a rising edge.
  - in_ready is combinational: in_ready = !(out_valid && !out_ready).
- Global stall: when out_valid && !out_ready, every stage holds.
  - s, cout, ovf and zero stay stable while out_valid=1 and out_ready=0.
  - Bubbles are not collapsed during a stall.
- Bubbles: a cycle with no input transfer inserts an invalid stage. Invalid stages never assert out_valid.
- Ordering: results leave in acceptance order. No loss, no duplication.
- When out_valid=0, s, cout, ovf and zero hold their last values.
- STAGES=1: single registered stage, latency 1, same handshake.
- Simultaneous final-stage output transfer and new input acceptance in the same cycle: both occur, and the pipeline advances.

Optional Feature:
- Macro: ADDSUB_SATURATE_EN.
- Defined:
  - Adds input port sat (1 bit), captured with the operands and skewed with the beat.
  - If sat=1 and ovf=1, s is clamped: 0x7FFF-pattern when the true result is positive (a[MSB] = 0), 0x8000-pattern otherwise.
  - ovf and cout still report the unclamped flags. zero is computed on the clamped s.
- Not defined: no sat port; results always wrap modulo 2^WIDTH.

Test Plan (WIDTH=16, STAGES=2 unless noted):
- a=0x7FFF, b=0x0001, m=0 -> 2 cycles later: s=0x8000, ovf=1, cout=0, zero=0. With SATURATE_EN and sat=1: s=0x7FFF, ovf=1.
- a=0x0005, b=0x0005, m=1 -> s=0x0000, zero=1, cout=1, ovf=0. Then a=0x0000, b=0x0001, m=1 -> s=0xFFFF, cout=0, ovf=0.
- a=0x8000, b=0x0001, m=1 -> s=0x7FFF, ovf=1, cout=1. Then a=0x00FF, b=0x0001, m=0 -> s=0x0100, checking the registered carry crossing the chunk boundary.
- Stream 8 beats back-to-back, with out_ready=0 for 3 cycles mid-stream:
  - in_ready=0 during the stall; s is held stable.
  - All 8 results arrive in order with no duplicates.
  - Random bubbles on in_valid are never emitted.
- Reset: assert rst_n=0 with 2 beats in flight -> out_valid=0 immediately (asynchronous), flags=0, nothing emitted after release.
- Random sweep at WIDTH=8/STAGES=4 and WIDTH=32/STAGES=1 against a reference model for s, cout, ovf and zero.
